// File: rtl/unidade_busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
package unidade_busca_pkg;

    localparam int LARGURA = 32;

    localparam logic [LARGURA-1:0] NOP_PADRAO = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_busca.sv
// Instruction fetch: PC -> req/ack memory read -> valid/consume to decode; 1-cycle issue, ack-edge capture.
// Decode backpressure holds the word in PRONTO; a taken branch discards any in-flight fetch.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int unsigned        TIMEOUT = 16,
    parameter logic [LARGURA-1:0] NOP     = NOP_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] endereco_pc,
    input  logic               desvio,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [LARGURA-1:0] mem_dado,
    output logic [LARGURA-1:0] instrucao,
    output logic               instrucao_valida,
    input  logic               consumo,
    output logic               pc_avanca,
    output logic               erro_alinhamento,
    output logic               erro_timeout
);

    localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

    estado_t    estado;
    logic       descarte;
    logic [7:0] contador;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado           <= OCIOSO;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            instrucao        <= NOP;
            instrucao_valida <= 1'b0;
            pc_avanca        <= 1'b0;
            erro_alinhamento <= 1'b0;
            erro_timeout     <= 1'b0;
            descarte         <= 1'b0;
            contador         <= '0;
        end else begin
            pc_avanca <= 1'b0;
            case (estado)
                OCIOSO: begin
                    // Either error flag parks the unit until reset.
                    if (!(erro_alinhamento || erro_timeout)) begin
                        if (endereco_pc[1:0] != 2'b00) begin
                            erro_alinhamento <= 1'b1;
                        end else begin
                            mem_addr <= endereco_pc;
                            mem_req  <= 1'b1;
                            contador <= '0;
                            descarte <= 1'b0;
                            estado   <= ESPERA;
                        end
                    end
                end
                ESPERA: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (descarte || desvio) begin
                            estado <= OCIOSO;
                        end else begin
                            instrucao        <= mem_dado;
                            instrucao_valida <= 1'b1;
                            pc_avanca        <= 1'b1;
                            estado           <= PRONTO;
                        end
                    end else begin
                        // No abort on the bus: remember the kill and keep waiting for the ack.
                        if (desvio) begin
                            descarte <= 1'b1;
                        end
                        if (contador == LIMITE) begin
                            mem_req      <= 1'b0;
                            erro_timeout <= 1'b1;
                            estado       <= OCIOSO;
                        end else begin
                            contador <= contador + 8'd1;
                        end
                    end
                end
                PRONTO: begin
                    if (desvio) begin
                        instrucao_valida <= 1'b0;
                        estado           <= OCIOSO;
                    end else if (consumo) begin
                        instrucao_valida <= 1'b0;
                        if (endereco_pc[1:0] != 2'b00) begin
                            erro_alinhamento <= 1'b1;
                            estado           <= OCIOSO;
                        end else begin
                            mem_addr <= endereco_pc;
                            mem_req  <= 1'b1;
                            contador <= '0;
                            descarte <= 1'b0;
                            estado   <= ESPERA;
                        end
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca, built with TIMEOUT=4.
module tb_unidade_busca;
    import unidade_busca_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] endereco_pc = '0;
    logic        desvio = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_dado = '0;
    logic [31:0] instrucao;
    logic        instrucao_valida;
    logic        consumo = 1'b0;
    logic        pc_avanca;
    logic        erro_alinhamento;
    logic        erro_timeout;

    int n_cmp = 0;
    int n_err = 0;

    unidade_busca #(.TIMEOUT(4), .NOP(32'h0000_0013)) dut (
        .clock            (clock),
        .reset            (reset),
        .endereco_pc      (endereco_pc),
        .desvio           (desvio),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_dado         (mem_dado),
        .instrucao        (instrucao),
        .instrucao_valida (instrucao_valida),
        .consumo          (consumo),
        .pc_avanca        (pc_avanca),
        .erro_alinhamento (erro_alinhamento),
        .erro_timeout     (erro_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_reset();
        reset = 1'b1; desvio = 1'b0; consumo = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        start_reset();
        tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (instrucao !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instrucao got %h want 00000013", instrucao); end
        n_cmp++; if ({instrucao_valida, pc_avanca, erro_alinhamento, erro_timeout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {instrucao_valida, pc_avanca, erro_alinhamento, erro_timeout});
        end
    endtask

    task automatic test_basic_fetch();
        int pulses = 0;
        start_reset();
        endereco_pc = 32'h4;
        reset = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
            n_err++; $display("FAIL basic_req got req=%b addr=%h want req=1 addr=00000004", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_dado = 32'h0050_0093;
        tick();
        mem_ack = 1'b0;
        if (pc_avanca) pulses++;
        n_cmp++; if (instrucao_valida !== 1'b1 || instrucao !== 32'h0050_0093 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL basic_capture got v=%b i=%h req=%b want v=1 i=00500093 req=0", instrucao_valida, instrucao, mem_req);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pc_avanca) pulses++;
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL basic_pc_avanca got %0d pulses want 1", pulses); end
        n_cmp++; if (instrucao_valida !== 1'b1 || instrucao !== 32'h0050_0093) begin
            n_err++; $display("FAIL basic_hold got v=%b i=%h want v=1 i=00500093", instrucao_valida, instrucao);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[$];
        bit busy = 0;
        int lat = 0;
        int pulses = 0;
        int cyc = 0;
        start_reset();
        endereco_pc = 32'h0;
        consumo = 1'b1;
        reset = 1'b0;
        while (pulses < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (mem_ack) busy = 0;
            mem_ack = 1'b0;
            if (mem_req && !busy) begin
                addrs.push_back(mem_addr);
                busy = 1;
                lat = 0;
            end
            if (busy) begin
                lat++;
                if (lat == 3) begin
                    mem_ack = 1'b1;
                    mem_dado = 32'h1000_0000 | mem_addr;
                end
            end
            if (pc_avanca) begin
                pulses++;
                endereco_pc = endereco_pc + 32'd4;
                if (pulses == 3) consumo = 1'b0;
            end
        end
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses got %0d want 3 within 60 cycles", pulses); end
        n_cmp++; if (addrs.size() != 3) begin n_err++; $display("FAIL b2b_req_count got %0d want 3", addrs.size()); end
        for (int k = 0; k < 3 && k < addrs.size(); k++) begin
            n_cmp++; if (addrs[k] !== 32'(k * 4)) begin
                n_err++; $display("FAIL b2b_addr[%0d] got %h want %h", k, addrs[k], 32'(k * 4));
            end
        end
        n_cmp++; if (instrucao !== 32'h1000_0008 || instrucao_valida !== 1'b1) begin
            n_err++; $display("FAIL b2b_last got v=%b i=%h want v=1 i=10000008", instrucao_valida, instrucao);
        end
    endtask

    task automatic test_branch_kill();
        int bad = 0;
        start_reset();
        endereco_pc = 32'h10;
        reset = 1'b0;
        tick();
        tick();
        desvio = 1'b1; endereco_pc = 32'h20;
        tick();
        desvio = 1'b0;
        if (mem_req !== 1'b1) bad++;
        tick();
        if (mem_req !== 1'b1) bad++;
        if (instrucao_valida !== 1'b0 || pc_avanca !== 1'b0) bad++;
        mem_ack = 1'b1; mem_dado = 32'hdead_beef;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL kill_wait got %0d bad cycles want 0", bad); end
        n_cmp++; if (instrucao_valida !== 1'b0 || pc_avanca !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL kill_ack got v=%b pa=%b req=%b want 0 0 0", instrucao_valida, pc_avanca, mem_req);
        end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            n_err++; $display("FAIL kill_next got req=%b addr=%h want req=1 addr=00000020", mem_req, mem_addr);
        end
    endtask

    task automatic test_misalign();
        int reqs = 0;
        start_reset();
        endereco_pc = 32'h6;
        reset = 1'b0;
        tick();
        n_cmp++; if (erro_alinhamento !== 1'b1) begin n_err++; $display("FAIL align_flag got %b want 1", erro_alinhamento); end
        endereco_pc = 32'h8;
        for (int k = 0; k < 5; k++) begin
            if (mem_req) reqs++;
            tick();
        end
        n_cmp++; if (reqs != 0 || erro_alinhamento !== 1'b1) begin
            n_err++; $display("FAIL align_sticky got reqs=%0d flag=%b want reqs=0 flag=1", reqs, erro_alinhamento);
        end
        reset = 1'b1;
        tick();
        n_cmp++; if (erro_alinhamento !== 1'b0) begin n_err++; $display("FAIL align_clear got %b want 0", erro_alinhamento); end
    endtask

    task automatic test_timeout();
        int high = 0;
        start_reset();
        endereco_pc = 32'h40;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_req) high++;
        end
        n_cmp++; if (high != 4) begin n_err++; $display("FAIL timeout_req_cycles got %0d want 4", high); end
        n_cmp++; if (mem_req !== 1'b0 || erro_timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_flag got req=%b err=%b want req=0 err=1", mem_req, erro_timeout);
        end
    endtask

    task automatic test_reset_mid_fetch();
        start_reset();
        endereco_pc = 32'h80;
        reset = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midrst_pre got req=%b want 1", mem_req); end
        reset = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b0 || instrucao !== 32'h0000_0013 || dut.estado !== OCIOSO) begin
            n_err++; $display("FAIL midrst_state got req=%b i=%h st=%0d want req=0 i=00000013 st=0", mem_req, instrucao, dut.estado);
        end
        reset = 1'b0;
        mem_ack = 1'b1; mem_dado = 32'hcafe_f00d;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (instrucao_valida !== 1'b0 || instrucao !== 32'h0000_0013 || mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            n_err++; $display("FAIL midrst_late_ack got v=%b i=%h req=%b addr=%h want v=0 i=00000013 req=1 addr=00000080",
                              instrucao_valida, instrucao, mem_req, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_branch_kill();
        test_misalign();
        test_timeout();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
